// File: rtl/paillier_result_collector_pkg.sv
// paillier_result_collector_pkg: shared constants, op codes and collector state encoding
package paillier_result_collector_pkg;
  localparam int COL_DATA_W    = 128;
  localparam int COL_MAX_WORDS = 32;
  localparam int COL_CNT_W     = 6;
  localparam logic [3:0] OP_ENCRY    = 4'b0001;
  localparam logic [3:0] OP_DECRY    = 4'b0010;
  localparam logic [3:0] OP_HOMO_ADD = 4'b0100;
  localparam logic [3:0] OP_HOMO_MUL = 4'b1000;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } col_state_e;
endpackage

// File: rtl/paillier_word_buf.sv
// paillier_word_buf: unreset register file, one sync write port, one async read port
module paillier_word_buf #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  // store one word on the edge of a write cycle
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/paillier_result_collector.sv
// paillier_result_collector: buffers a core result stream and replays it over valid/ready
module paillier_result_collector
  import paillier_result_collector_pkg::*;
#(
  parameter int DATA_W    = COL_DATA_W,
  parameter int MAX_WORDS = COL_MAX_WORDS,
  parameter int CNT_W     = COL_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_output_start,
  input  logic              in_done,
  input  logic [DATA_W-1:0] in_result,
  input  logic [3:0]        in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_index,
  output logic              out_last,
  output logic [3:0]        out_op,
  output logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic [1:0]        err
);
  localparam int AW = $clog2(MAX_WORDS);
  col_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [3:0]        op_q, op_d;
  logic [1:0]        err_q, err_d;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [DATA_W-1:0] rdata;
  logic              drain, last;
  paillier_word_buf #(.DATA_W(DATA_W), .DEPTH(MAX_WORDS), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (in_result),
    .raddr (ptr_q),
    .rdata (rdata)
  );
  assign drain      = state_q == ST_DRAIN;
  assign last       = drain && (CNT_W'(ptr_q) == cnt_q - CNT_W'(1));
  assign out_valid  = drain;
  assign out_data   = drain ? rdata : '0;
  assign out_index  = CNT_W'(ptr_q);
  assign out_last   = last;
  assign out_op     = op_q;
  assign word_count = cnt_q;
  assign busy       = state_q != ST_IDLE;
  assign err        = err_q;
  // next state: capture words at the core's rate, drain under consumer handshake
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    err_d   = err_q;
    we      = 1'b0;
    waddr   = cnt_q[AW-1:0];
    if (state_q == ST_IDLE) begin
      if (in_output_start) begin
        we      = 1'b1;
        waddr   = '0;
        cnt_d   = CNT_W'(1);
        op_d    = in_op;
        err_d   = '0;
        state_d = in_done ? ST_DRAIN : ST_CAPTURE;
      end
    end else if (state_q == ST_CAPTURE) begin
      if (in_output_start) err_d[1] = 1'b1;
      if (in_done) state_d = ST_DRAIN;
      else if (!in_output_start) begin
        if (cnt_q == CNT_W'(MAX_WORDS)) err_d[0] = 1'b1;
        else begin
          we    = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end else begin
      if (in_output_start) err_d[1] = 1'b1;
      if (out_ready) begin
        ptr_d   = last ? '0 : ptr_q + AW'(1);
        state_d = last ? ST_IDLE : ST_DRAIN;
      end
    end
  end
  // state and bookkeeping registers, cleared immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      op_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_paillier_result_collector.sv
// tb_paillier_result_collector: randomized jobs checked against a queue-based delivery model
module tb_paillier_result_collector;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_output_start = 1'b0;
  logic         in_done = 1'b0;
  logic [127:0] in_result = '0;
  logic [3:0]   in_op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic [5:0]   out_index;
  logic         out_last;
  logic [3:0]   out_op;
  logic [5:0]   word_count;
  logic         busy;
  logic [1:0]   err;
  int n_chk = 0;
  int n_fail = 0;
  logic [127:0] wq[$];
  paillier_result_collector dut (
    .clk             (clk),
    .rst             (rst),
    .in_output_start (in_output_start),
    .in_done         (in_done),
    .in_result       (in_result),
    .in_op           (in_op),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_index       (out_index),
    .out_last        (out_last),
    .out_op          (out_op),
    .word_count      (word_count),
    .busy            (busy),
    .err             (err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic chk_idle(input string tag, input logic [5:0] cnt, input logic [3:0] op, input logic [1:0] e);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_index"}, out_index, 0);
    chk({tag, "_count"}, word_count, cnt);
    chk({tag, "_op"}, out_op, op);
    chk({tag, "_err"}, err, e);
  endtask
  function automatic logic [127:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  // one job: the words in wq are streamed, done follows, then the drain is checked word by word
  task automatic job(input logic [3:0] op, input bit same, input bit coll, input int mode, input int abort_at);
    int n = wq.size();
    int m = (n > 32) ? 32 : n;
    logic [1:0] e_err = {1'b0, n > 32};
    int k = 0;
    int c = 0;
    bit r;
    @(negedge clk);
    in_output_start = 1'b1;
    in_result = wq[0];
    in_op = op;
    in_done = same;
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      in_output_start = 1'b0;
      in_result = wq[i];
    end
    if (!same) begin
      @(negedge clk);
      in_output_start = 1'b0;
      in_done = 1'b1;
      in_result = rnd_word();
    end
    @(negedge clk);
    in_done = 1'b0;
    in_output_start = 1'b0;
    while (k < m && c < 1000) begin
      if (k == abort_at) return;
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, wq[k]);
      chk("drain_index", out_index, k);
      chk("drain_last", out_last, k == m - 1);
      chk("drain_op", out_op, op);
      chk("drain_count", word_count, m);
      chk("drain_busy", busy, 1);
      if (c == 0) chk("drain_err_first", err, e_err);
      in_output_start = coll && c == 1;
      in_result = rnd_word();
      if (in_output_start) e_err[1] = 1'b1;
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 3 == 0) : 1'($urandom % 2);
      out_ready = r;
      if (r) k++;
      c++;
      @(negedge clk);
    end
    in_output_start = 1'b0;
    out_ready = 1'b0;
    chk("drain_complete", k, m);
    chk_idle("post", 6'(m), op, e_err);
  endtask
  initial begin
    logic [3:0] op;
    int n;
    #1;
    chk_idle("reset", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    wq = {128'h08};
    for (int i = 1; i < 32; i++) wq.push_back(128'(i));
    job(4'b0001, 0, 0, 0, -1);
    wq = {rnd_word(), rnd_word(), rnd_word(), rnd_word()};
    job(4'b0100, 0, 0, 1, -1);
    wq = {128'h82F4};
    job(4'b0010, 1, 0, 0, -1);
    wq = {};
    for (int i = 0; i < 34; i++) wq.push_back(rnd_word());
    job(4'b0001, 0, 0, 2, -1);
    wq = {rnd_word(), rnd_word()};
    job(4'b1000, 0, 1, 0, -1);
    wq = {rnd_word(), rnd_word(), rnd_word()};
    job(4'b0001, 0, 0, 0, -1);
    wq = {};
    for (int i = 0; i < 8; i++) wq.push_back(rnd_word());
    job(4'b0100, 0, 0, 0, 2);
    rst = 1'b1;
    out_ready = 1'b0;
    #1;
    chk_idle("midreset", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    wq = {rnd_word(), rnd_word(), rnd_word()};
    job(4'b1000, 0, 0, 2, -1);
    for (int j = 0; j < 20; j++) begin
      n = $urandom_range(1, 36);
      op = 4'b0001 << $urandom_range(0, 3);
      wq = {};
      for (int i = 0; i < n; i++) wq.push_back(rnd_word());
      job(op, n == 1 && $urandom % 2 == 1, n >= 2 && $urandom % 2 == 1, $urandom_range(0, 2), -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/paillier_result_collector.md
# paillier_result_collector

Downstream stage of the Paillier latency-test block: captures the multi-word result stream (`result` words framed by `output_start` … `done`) into a local word buffer, tags it with the operation that produced it, then replays it to a host-side consumer over a valid/ready handshake. Decouples the core's fixed-rate, unstallable output from a host that may back-pressure, so a full 4096-bit result is never lost.

## Interface
Parameters:
- `DATA_W`, 128, width of one result word
- `MAX_WORDS`, 32, buffer depth in words (4096 / 128)
- `CNT_W`, 6, width of word counters; must hold `MAX_WORDS` inclusive

Ports:
- `clk`  in  1  single clock, all logic rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `in_output_start`  in  1  first-word strobe from core; `in_result` valid this cycle
- `in_done`  in  1  end-of-stream strobe from core; carries no word
- `in_result`  in  DATA_W  result word from core
- `in_op`  in  4  one-hot op of the current job (0001 encry, 0010 decry, 0100 homo add, 1000 homo mul)
- `out_valid`  out  1  `out_data` holds a buffered word
- `out_ready`  in  1  consumer accepts word when high with `out_valid`
- `out_data`  out  DATA_W  buffered word, index order
- `out_index`  out  CNT_W  index of word on `out_data`, 0-based
- `out_last`  out  1  high with final buffered word
- `out_op`  out  4  `in_op` sampled at the accepted `in_output_start`
- `word_count`  out  CNT_W  words stored for current job
- `busy`  out  1  high in CAPTURE or DRAIN
- `err`  out  2  sticky: bit0 overflow (words dropped), bit1 start collision

## Operation
- States: IDLE, CAPTURE, DRAIN.
- IDLE: `in_output_start`=1 → write `in_result` at index 0, `word_count`←1, latch `out_op`←`in_op`, clear `err`, go CAPTURE. If `in_done` also high same cycle → go DRAIN instead (one-word job).
- CAPTURE: each cycle with `in_done`=0 is a word cycle: write `in_result` at `word_count`, increment. `in_done`=1 → no write, go DRAIN.
- Overflow: word cycle with `word_count`=`MAX_WORDS` → word dropped, count holds, `err[0]`←1.
- DRAIN: read pointer starts 0; `out_valid`=1; `out_data`=buf[ptr], `out_index`=ptr, `out_last`=(ptr==`word_count`-1). Handshake (`out_valid`&`out_ready`) advances ptr; handshake on `out_last` → IDLE.
- `in_output_start` in CAPTURE or DRAIN: ignored (no write, no state change), `err[1]`←1. `in_done` in IDLE or DRAIN: ignored.
- `out_data`/`out_index`/`out_last`/`out_op` must hold stable while `out_valid`=1 and `out_ready`=0.
- `word_count`, `out_op`, `err` hold their values after return to IDLE until the next accepted start.

## Timing
- Reset: state IDLE, read pointer 0; `out_valid`, `out_last`, `busy` = 0; `out_index`, `word_count`, `out_op`, `err` = 0; `out_data` = 0 (buffer need not be cleared, but `out_data` is gated to 0 outside DRAIN).
- Capture: one word per cycle, no back-pressure to core; write takes effect on the edge of the word cycle.
- `in_done` at edge N → `out_valid`=1 from cycle N+1; first word available then.
- With `out_ready` held high, K words drain in K cycles; `busy` falls the cycle after last handshake.
- Earliest next accepted start: cycle after DRAIN → IDLE transition.
- Reset asserted mid-CAPTURE or mid-DRAIN: immediate return to reset values; partial job discarded, no `out_last` issued.

## Structure
- Shared constants in `_parameter.v`: `DATA_W`, `MAX_WORDS`, `CNT_W`, one-hot op codes, collector state encodings.
- One sub-module: `paillier_word_buf` — `MAX_WORDS`×`DATA_W` register file, one synchronous write port, one asynchronous read port, no reset on storage. FSM, counters, flags in the top.

## Test plan
- Encry job: start with word 0x08 then words 0x01..0x1F (32 total), `done` next cycle, `out_ready`=1 → 32 words out in order, `out_index` 0..31, `out_last` only at 31, `out_op`=0001, `err`=0.
- Back-pressure: 4-word homo add job (op 0100), `out_ready` toggled 1,0,0,1,… → each word held stable while stalled, all 4 delivered once, `out_last` on index 3.
- One-word job: `in_output_start` and `in_done` same cycle with word 0x82F4 (decry 0010) → `out_valid` next cycle, single word, `out_last`=1, `word_count`=1.
- Overflow: 34 word cycles before `done` → 32 words delivered (first 32), `err[0]`=1, `word_count`=32.
- Collision: second `in_output_start` during DRAIN of a 2-word homo mul job → ignored, 2 words delivered unchanged, `err[1]`=1; next start after IDLE clears `err`.
- Reset mid-DRAIN after 2 of 8 words → all outputs to reset values next sample; fresh 3-word job then drains correctly from index 0.
